// File: rtl/compuerta_tiempo_muerto_if.sv
// Bundle carrying the raw SPWM requests, enable/fault control and the guarded
// H-bridge gate drives between the PWM source and the dead-time guard.
interface compuerta_tiempo_muerto_if;
    logic       pwm_Pos;
    logic       pwm_Neg;
    logic       enable;
    logic       fault_clr;
    logic       gate_P;
    logic       gate_N;
    logic       fault;
    logic [7:0] fault_cnt;

    modport master (
        output pwm_Pos, pwm_Neg, enable, fault_clr,
        input  gate_P, gate_N, fault, fault_cnt
    );

    modport slave (
        input  pwm_Pos, pwm_Neg, enable, fault_clr,
        output gate_P, gate_N, fault, fault_cnt
    );
endinterface

// File: rtl/compuerta_tiempo_muerto.sv
// Dead-time / shoot-through guard between the SPWM generators and the H-bridge:
// gate_P drives Q1+Q4, gate_N drives Q2+Q3, never both, with DEAD_T+1 clocks off between conductions.
module compuerta_tiempo_muerto #(
    parameter int DEAD_T = 50,
    parameter int CNT_W  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    compuerta_tiempo_muerto_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON_P  = 2'd1,
        ON_N  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DT_MAX = DEAD_T[CNT_W-1:0];

    state_t           r_state;
    logic [CNT_W-1:0] r_dt_cnt;
    logic             r_P;
    logic             r_N;
    logic             r_gate_P;
    logic             r_gate_N;
    logic             r_fault;
    logic [7:0]       r_fault_cnt;
    logic             w_both;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_both        = r_P & r_N;
    assign bus.gate_P    = r_gate_P;
    assign bus.gate_N    = r_gate_N;
    assign bus.fault     = r_fault;
    assign bus.fault_cnt = r_fault_cnt;

    // Input register: the FSM only ever looks at these sampled copies.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_P <= 1'b0;
            r_N <= 1'b0;
        end else begin
            r_P <= bus.pwm_Pos;
            r_N <= bus.pwm_Neg;
        end
    end

    // Guard FSM; gate and fault registers are loaded with the decode of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dt_cnt    <= '0;
            r_gate_P    <= 1'b0;
            r_gate_N    <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_both) begin
                        r_state     <= FAULT;
                        r_fault     <= 1'b1;
                        r_fault_cnt <= sat_inc8(r_fault_cnt);
                        r_dt_cnt    <= '0;
                    end else if (!bus.enable) begin
                        r_dt_cnt <= '0;
                    end else if (r_dt_cnt == DT_MAX && r_P) begin
                        r_state  <= ON_P;
                        r_gate_P <= 1'b1;
                        r_dt_cnt <= '0;
                    end else if (r_dt_cnt == DT_MAX && r_N) begin
                        r_state  <= ON_N;
                        r_gate_N <= 1'b1;
                        r_dt_cnt <= '0;
                    end else if (r_dt_cnt != DT_MAX) begin
                        r_dt_cnt <= r_dt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_dt_cnt <= r_dt_cnt;
                    end
                end
                ON_P: begin
                    if (w_both) begin
                        r_state     <= FAULT;
                        r_gate_P    <= 1'b0;
                        r_fault     <= 1'b1;
                        r_fault_cnt <= sat_inc8(r_fault_cnt);
                    end else if (!bus.enable || !r_P) begin
                        r_state  <= IDLE;
                        r_gate_P <= 1'b0;
                        r_dt_cnt <= '0;
                    end else begin
                        r_state <= ON_P;
                    end
                end
                ON_N: begin
                    if (w_both) begin
                        r_state     <= FAULT;
                        r_gate_N    <= 1'b0;
                        r_fault     <= 1'b1;
                        r_fault_cnt <= sat_inc8(r_fault_cnt);
                    end else if (!bus.enable || !r_N) begin
                        r_state  <= IDLE;
                        r_gate_N <= 1'b0;
                        r_dt_cnt <= '0;
                    end else begin
                        r_state <= ON_N;
                    end
                end
                FAULT: begin
                    // Clearing is refused while either request is still asserted.
                    if (bus.fault_clr && !r_P && !r_N) begin
                        r_state  <= IDLE;
                        r_fault  <= 1'b0;
                        r_dt_cnt <= '0;
                    end else begin
                        r_state <= FAULT;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_gate_P <= 1'b0;
                    r_gate_N <= 1'b0;
                    r_fault  <= 1'b0;
                    r_dt_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compuerta_tiempo_muerto.sv
// Directed bench for the dead-time guard with DEAD_T=4; every expectation is hand-derived
// from edge counts (input register + state register + DEAD_T+1 idle clocks).
module tb_compuerta_tiempo_muerto;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    compuerta_tiempo_muerto_if bus ();

    compuerta_tiempo_muerto #(.DEAD_T(4), .CNT_W(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pwm_Pos = 1'b0; bus.pwm_Neg = 1'b0;
        bus.enable = 1'b1;  bus.fault_clr = 1'b0;
        step(3);
        vectors++;
        if (bus.gate_P !== 1'b0 || bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gates: got P=%b N=%b expected 0 0", bus.gate_P, bus.gate_N);
        end
        vectors++;
        if (bus.fault !== 1'b0 || bus.fault_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_fault: got fault=%b cnt=%0d expected 0 0", bus.fault, bus.fault_cnt);
        end
    endtask

    // Pos held through reset: dt counts 1..4 on edges 1..4 after release, ON_P on edge 5.
    task automatic test_startup();
        bus.pwm_Pos = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        vectors++;
        if (bus.gate_P !== 1'b0) begin
            miscompares++;
            $display("FAIL startup_early: got gate_P=%b expected 0", bus.gate_P);
        end
        step(1);
        vectors++;
        if (bus.gate_P !== 1'b1 || bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL startup_rise: got P=%b N=%b expected 1 0", bus.gate_P, bus.gate_N);
        end
    endtask

    // Pos falls, Neg rises one clock later: gate_P low 2 edges after the fall, gate_N 5 edges after that.
    task automatic test_swap();
        bus.pwm_Pos = 1'b0;
        step(1);
        vectors++;
        if (bus.gate_P !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_pipe: got gate_P=%b expected 1", bus.gate_P);
        end
        bus.pwm_Neg = 1'b1;
        step(1);
        vectors++;
        if (bus.gate_P !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_fall: got gate_P=%b expected 0", bus.gate_P);
        end
        step(4);
        vectors++;
        if (bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_deadtime: got gate_N=%b expected 0", bus.gate_N);
        end
        step(1);
        vectors++;
        if (bus.gate_N !== 1'b1 || bus.gate_P !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_rise: got P=%b N=%b expected 0 1", bus.gate_P, bus.gate_N);
        end
    endtask

    task automatic test_enable_drop();
        bus.enable = 1'b0;
        step(1);
        vectors++;
        if (bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop: got gate_N=%b expected 0", bus.gate_N);
        end
        step(3);
        bus.enable = 1'b1;
        step(4);
        vectors++;
        if (bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_deadtime: got gate_N=%b expected 0", bus.gate_N);
        end
        step(1);
        vectors++;
        if (bus.gate_N !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_restore: got gate_N=%b expected 1", bus.gate_N);
        end
    endtask

    task automatic test_fault();
        bus.pwm_Neg = 1'b0;
        bus.pwm_Pos = 1'b1;
        step(10);
        vectors++;
        if (bus.gate_P !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_setup: got gate_P=%b expected 1", bus.gate_P);
        end
        bus.pwm_Neg = 1'b1;
        step(1);
        bus.pwm_Neg = 1'b0;
        step(1);
        vectors++;
        if (bus.fault !== 1'b1 || bus.gate_P !== 1'b0 || bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_entry: got fault=%b P=%b N=%b expected 1 0 0", bus.fault, bus.gate_P, bus.gate_N);
        end
        vectors++;
        if (bus.fault_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL fault_cnt1: got %0d expected 1", bus.fault_cnt);
        end
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        step(1);
        vectors++;
        if (bus.fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_clr_ignored: got fault=%b expected 1", bus.fault);
        end
        bus.pwm_Pos = 1'b0;
        step(2);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        vectors++;
        if (bus.fault !== 1'b0 || bus.fault_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL fault_clear: got fault=%b cnt=%0d expected 0 1", bus.fault, bus.fault_cnt);
        end
    endtask

    // A 2-clock Pos pulse right after a gate fall ends before the dead time expires.
    task automatic test_short_request();
        int highs;
        bus.pwm_Pos = 1'b1;
        step(7);
        vectors++;
        if (bus.gate_P !== 1'b1) begin
            miscompares++;
            $display("FAIL short_setup: got gate_P=%b expected 1", bus.gate_P);
        end
        bus.pwm_Pos = 1'b0;
        step(2);
        vectors++;
        if (bus.gate_P !== 1'b0) begin
            miscompares++;
            $display("FAIL short_fall: got gate_P=%b expected 0", bus.gate_P);
        end
        bus.pwm_Pos = 1'b1;
        step(2);
        bus.pwm_Pos = 1'b0;
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.gate_P === 1'b1 || bus.gate_N === 1'b1) highs++;
        end
        vectors++;
        if (highs !== 0) begin
            miscompares++;
            $display("FAIL short_lost: got %0d gate-high clocks expected 0", highs);
        end
    endtask

    // 300 entries on top of the one already logged: count reads 102 after 101 loops, then pins at 255.
    task automatic test_fault_saturation();
        for (int i = 0; i < 300; i++) begin
            bus.pwm_Pos = 1'b1; bus.pwm_Neg = 1'b1;
            step(1);
            bus.pwm_Pos = 1'b0; bus.pwm_Neg = 1'b0;
            step(2);
            bus.fault_clr = 1'b1;
            step(1);
            bus.fault_clr = 1'b0;
            if (i == 100) begin
                vectors++;
                if (bus.fault_cnt !== 8'd102) begin
                    miscompares++;
                    $display("FAIL sat_midway: got %0d expected 102", bus.fault_cnt);
                end
            end
        end
        vectors++;
        if (bus.fault_cnt !== 8'd255 || bus.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_top: got cnt=%0d fault=%b expected 255 0", bus.fault_cnt, bus.fault);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (bus.fault_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL sat_reset: got %0d expected 0", bus.fault_cnt);
        end
    endtask

    task automatic test_reset_mid_conduction();
        rst = 1'b0;
        bus.pwm_Pos = 1'b1;
        step(7);
        vectors++;
        if (bus.gate_P !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_setup: got gate_P=%b expected 1", bus.gate_P);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (bus.gate_P !== 1'b0 || bus.gate_N !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_gates: got P=%b N=%b expected 0 0", bus.gate_P, bus.gate_N);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_startup();
        test_swap();
        test_enable_drop();
        test_fault();
        test_short_request();
        test_fault_saturation();
        test_reset_mid_conduction();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
